// File: rtl/add2bit_bist.sv
// Built-in self-test engine for the 2-bit ripple adder add2bit.
// Sweeps all 32 {cin, a, b} operand combinations, checks {co, s} against
// a + b + cin, and reports pass/fail, the error count and the first
// failing vector.
module add2bit_bist #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] dut_a,
    output logic [1:0] dut_b,
    output logic       dut_cin,
    input  logic [1:0] dut_s,
    input  logic       dut_co,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [4:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // Settle counter is at least one bit wide, even when it only ever holds 0.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    state_t        state;
    logic [4:0]    vec;
    logic [CW-1:0] settle_cnt;

    logic [2:0]    exp_sum;
    logic [2:0]    got_sum;
    logic          mismatch;
    logic [5:0]    err_next;

    // Operands come straight from the vector register: no path from inputs.
    assign dut_cin = vec[4];
    assign dut_a   = vec[3:2];
    assign dut_b   = vec[1:0];

    // Reference sum for the current vector and comparison with the adder.
    always_comb begin
        exp_sum  = {1'b0, vec[3:2]} + {1'b0, vec[1:0]} + {2'b00, vec[4]};
        got_sum  = {dut_co, dut_s};
        mismatch = (got_sum != exp_sum);
        err_next = err_count + {5'b00000, mismatch};
    end

    // Sweep controller: state, vector, counters and all registered results.
    // NOTE: every register here uses non-blocking assignment so that all of
    // them see the pre-edge values of each other within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= SETTLE;
                        settle_cnt       <= SETTLE_LOAD;
                        vec              <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (vec == 5'd31) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // NOTE: pass uses err_next so a failure on the last
                        // vector is not missed by the one-edge-late err_count.
                        pass  <= (err_next == 6'd0);
                    end else begin
                        vec        <= vec + 5'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add2bit_bist.sv
// Self-checking bench for add2bit_bist: drives the BIST against a stand-in
// adder with selectable faults and compares against a vector-level model.
module tb_add2bit_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;

    always #5 clk = ~clk;

    // ---- instance 1: default settle, faultable adder ----
    logic [1:0] a, b, s;
    logic       cin, co;
    logic       busy, done, pass, ffvalid;
    logic [5:0] err;
    logic [4:0] ffv;

    // 0 = good, 1 = CO stuck 0, 2 = S[0] stuck 0, 3 = random per-vector xor
    int         fault_mode = 0;
    logic [2:0] xor_tab [32];

    logic [2:0] raw_sum;
    logic [2:0] faulty_sum;
    always_comb begin
        raw_sum    = {1'b0, a} + {1'b0, b} + {2'b00, cin};
        faulty_sum = raw_sum;
        case (fault_mode)
            1: faulty_sum = {1'b0, raw_sum[1:0]};
            2: faulty_sum = {raw_sum[2:1], 1'b0};
            3: faulty_sum = raw_sum ^ xor_tab[{cin, a, b}];
            default: faulty_sum = raw_sum;
        endcase
        co = faulty_sum[2];
        s  = faulty_sum[1:0];
    end

    add2bit_bist #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a), .dut_b(b), .dut_cin(cin),
        .dut_s(s), .dut_co(co),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err), .first_fail_vec(ffv), .first_fail_valid(ffvalid)
    );

    // ---- instance 2: SETTLE_CYCLES = 3, good adder ----
    logic [1:0] a2, b2, s2;
    logic       cin2, co2;
    logic       busy2, done2, pass2, ffvalid2;
    logic [5:0] err2;
    logic [4:0] ffv2;
    logic [2:0] sum2;

    always_comb begin
        sum2 = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
        co2  = sum2[2];
        s2   = sum2[1:0];
    end

    add2bit_bist #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start2),
        .dut_a(a2), .dut_b(b2), .dut_cin(cin2),
        .dut_s(s2), .dut_co(co2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail_vec(ffv2), .first_fail_valid(ffvalid2)
    );

    // ---- checking ----
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: which vectors the planted fault corrupts ----
    bit exp_mm [32];
    int exp_err;
    int exp_first;

    function automatic int fault_result(input int v);
        int good;
        int obs;
        good = ((v >> 2) & 3) + (v & 3) + ((v >> 4) & 1);
        obs  = good;
        if (fault_mode == 1) obs = good % 4;
        else if (fault_mode == 2) obs = good - (good % 2);
        else if (fault_mode == 3) obs = good ^ int'(xor_tab[v]);
        return obs;
    endfunction

    task automatic build_model();
        exp_err   = 0;
        exp_first = -1;
        for (int v = 0; v < 32; v++) begin
            int good;
            good      = ((v >> 2) & 3) + (v & 3) + ((v >> 4) & 1);
            exp_mm[v] = (fault_result(v) != good);
            if (exp_mm[v]) begin
                exp_err++;
                if (exp_first < 0) exp_first = v;
            end
        end
    endtask

    // Full sweep on instance 1, from IDLE or DONE. Optionally pulses start
    // mid-sweep, which must be ignored.
    task automatic run_sweep(input string tag, input bit glitch_starts);
        int bad;
        int err_exp_now;
        build_model();
        start = 1'b1;
        tick();                                 // edge k
        start = 1'b0;
        check({tag, " start_busy"}, {31'd0, busy}, 32'd1);
        check({tag, " start_clear"}, {done, pass, ffvalid, 1'b0, err}, 32'd0);
        check({tag, " start_vec"}, {27'd0, cin, a, b}, 32'd0);
        bad = 0;
        for (int i = 1; i < 64; i++) begin
            start = glitch_starts && (i == 5 || i == 20);
            tick();                             // edge k+i
            err_exp_now = 0;
            for (int v = 0; v < 32; v++)
                if (exp_mm[v] && (2 * v + 2 <= i)) err_exp_now++;
            if (!busy || done || pass) bad++;
            if ({cin, a, b} != 5'(i / 2)) bad++;
            if (int'(err) != err_exp_now) bad++;
        end
        start = 1'b0;
        check({tag, " during_sweep"}, bad, 0);
        tick();                                 // edge k+64
        check({tag, " done"}, {30'd0, busy, done}, 32'b01);
        check({tag, " pass"}, {31'd0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
        check({tag, " err_count"}, {26'd0, err}, exp_err);
        check({tag, " ff_valid"}, {31'd0, ffvalid}, (exp_err != 0) ? 32'd1 : 32'd0);
        if (exp_err != 0)
            check({tag, " ff_vec"}, {27'd0, ffv}, exp_first);
        tick();
        check({tag, " held"}, {done, pass, err}, {1'b1, exp_err == 0, 6'(exp_err)});
    endtask

    initial begin
        // Reset state of both instances.
        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", {busy, done, pass, err, ffv, ffvalid, a, b, cin}, 0);
        check("reset_outputs3", {busy2, done2, pass2, err2, ffv2, ffvalid2, a2, b2, cin2}, 0);
        rst = 1'b0;
        tick();
        check("idle_ignores_nothing", {31'd0, busy}, 0);

        fault_mode = 0;
        run_sweep("good", 1'b0);

        fault_mode = 1;
        run_sweep("co_stuck0", 1'b0);
        check("co_stuck0 err16", {26'd0, err}, 16);
        check("co_stuck0 ffv", {27'd0, ffv}, 32'b00111);

        fault_mode = 0;
        run_sweep("restart_good", 1'b1);

        fault_mode = 2;
        run_sweep("s0_stuck0", 1'b0);
        check("s0_stuck0 err16", {26'd0, err}, 16);
        check("s0_stuck0 ffv", {27'd0, ffv}, 32'b00001);

        for (int r = 0; r < 3; r++) begin
            fault_mode = 3;
            for (int v = 0; v < 32; v++)
                xor_tab[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            run_sweep("random_fault", 1'b0);
        end

        // Reset mid-sweep at vec 15.
        fault_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("midsweep_vec15", {27'd0, cin, a, b}, 15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midsweep_reset", {busy, done, pass, err, ffv, ffvalid, a, b, cin}, 0);
        tick();
        check("midsweep_idle", {30'd0, busy, done}, 0);
        run_sweep("after_reset", 1'b1);

        // SETTLE_CYCLES = 3: done at k+128, each vector held for 4 cycles.
        begin
            int bad;
            int cyc;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            check("s3 start_busy", {31'd0, busy2}, 1);
            bad = 0;
            cyc = 0;
            while (!done2 && cyc < 300) begin
                if ({cin2, a2, b2} != 5'(cyc / 4)) bad++;
                tick();
                cyc++;
            end
            check("s3 operand_hold", bad, 0);
            check("s3 done_cycle", cyc, 128);
            check("s3 result", {busy2, done2, pass2, err2, ffvalid2}, {3'b011, 6'd0, 1'b0});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
